siaminer_sched: RTL and testbench

Nonce scheduler and sequencer for the siaminer hash pipeline. It takes a work unit (base m04 word plus nonce count), flushes the pipeline, then issues one candidate m04 word per cycle into the head pipe stage. It drains the pipeline when the range is exhausted and captures the winning m04 word when the comparator at the pipeline tail reports a hit. It sits between the work-fetch interface and the head of the `pipe` chain, and drives that chain's `vldIn`/`m04In` and its clean (`valid`) input.

---
 rtl/siaminer_sched.sv | 151 +++++++++++++++
 tb/tb_siaminer_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/siaminer_sched.sv
// Nonce scheduler/sequencer for the siaminer hash pipeline: flush, issue, drain, capture hit.
// Optional hashrate counter on hashCnt enabled by defining SIAMINER_HASHRATE_CNT_EN.
module siaminer_sched #(
    parameter int unsigned PIPE_DEPTH = 8,
    parameter logic [63:0] NONCE_STEP = 64'd1,
    parameter logic [63:0] NONCE_OFS  = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        workVld,
    input  logic [63:0] workM04,
    input  logic [31:0] workCnt,
    input  logic        found,
    input  logic [63:0] foundM04,
    output logic        pipeVld,
    output logic [63:0] pipeM04,
    output logic        pipeClean,
    output logic        busy,
    output logic        resVld,
    output logic [63:0] resM04,
    output logic        exhausted,
    output logic [31:0] hashCnt
);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

    state_t      state, nxtState;
    logic [63:0] base, nxtBase;
    logic [31:0] limit, nxtLimit;
    logic [31:0] idx, nxtIdx;
    logic [31:0] drainCnt, nxtDrainCnt;
    logic        nxtPipeVld, nxtPipeClean, nxtResVld, nxtExhausted;
    logic [63:0] nxtPipeM04, nxtResM04;
    logic [63:0] issueM04;

    assign issueM04 = base + ({32'd0, idx} * NONCE_STEP);

    // Outputs are registered, so each state computes what the pipe sees next cycle;
    // FLUSH therefore already schedules idx 0 for the cycle after the clean pulse.
    always_comb begin
        nxtState     = state;
        nxtBase      = base;
        nxtLimit     = limit;
        nxtIdx       = idx;
        nxtDrainCnt  = drainCnt;
        nxtPipeVld   = 1'b0;
        nxtPipeM04   = pipeM04;
        nxtPipeClean = 1'b0;
        nxtResVld    = 1'b0;
        nxtResM04    = resM04;
        nxtExhausted = 1'b0;

        case (state)
            IDLE: begin
            end
            FLUSH, RUN: begin
                if (state == FLUSH && limit == 32'd0) begin
                    nxtState    = DRAIN;
                    nxtDrainCnt = 32'(PIPE_DEPTH);
                end else begin
                    nxtPipeVld = 1'b1;
                    nxtPipeM04 = issueM04;
                    nxtIdx     = idx + 32'd1;
                    if (idx == limit - 32'd1) begin
                        nxtState    = DRAIN;
                        nxtDrainCnt = 32'(PIPE_DEPTH);
                    end else begin
                        nxtState = RUN;
                    end
                end
            end
            DRAIN: begin
                if (drainCnt <= 32'd1) begin
                    nxtExhausted = 1'b1;
                    nxtState     = IDLE;
                end else begin
                    nxtDrainCnt = drainCnt - 32'd1;
                end
            end
            default: nxtState = IDLE;
        endcase

        // A hit ends the range; the pipe self-cleans, so no clean pulse here.
        if (found && (state == RUN || state == DRAIN)) begin
            nxtResVld    = 1'b1;
            nxtResM04    = foundM04;
            nxtPipeVld   = 1'b0;
            nxtExhausted = 1'b0;
            nxtState     = IDLE;
        end

        // New work always wins the next state, abandoning any range in flight.
        if (workVld) begin
            nxtBase      = workM04 + NONCE_OFS;
            nxtLimit     = workCnt;
            nxtIdx       = 32'd0;
            nxtPipeVld   = 1'b0;
            nxtPipeClean = 1'b1;
            nxtExhausted = 1'b0;
            nxtState     = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= 64'd0;
            limit     <= 32'd0;
            idx       <= 32'd0;
            drainCnt  <= 32'd0;
            pipeVld   <= 1'b0;
            pipeM04   <= 64'd0;
            pipeClean <= 1'b0;
            busy      <= 1'b0;
            resVld    <= 1'b0;
            resM04    <= 64'd0;
            exhausted <= 1'b0;
        end else begin
            state     <= nxtState;
            base      <= nxtBase;
            limit     <= nxtLimit;
            idx       <= nxtIdx;
            drainCnt  <= nxtDrainCnt;
            pipeVld   <= nxtPipeVld;
            pipeM04   <= nxtPipeM04;
            pipeClean <= nxtPipeClean;
            busy      <= (nxtState != IDLE);
            resVld    <= nxtResVld;
            resM04    <= nxtResM04;
            exhausted <= nxtExhausted;
        end
    end

`ifdef SIAMINER_HASHRATE_CNT_EN
    logic [31:0] hashReg;

    // Free-running issue count; only reset clears it, new work does not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hashReg <= 32'd0;
        end else begin
            hashReg <= hashReg + {31'd0, pipeVld};
        end
    end

    assign hashCnt = hashReg;
`else
    assign hashCnt = 32'd0;
`endif

endmodule

// File: tb/tb_siaminer_sched.sv
// Self-checking bench for siaminer_sched: table-driven issue sequence plus hand-written corner cases.
module tb_siaminer_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        workVld = 1'b0;
    logic [63:0] workM04 = 64'd0;
    logic [31:0] workCnt = 32'd0;
    logic        found = 1'b0;
    logic [63:0] foundM04 = 64'd0;

    logic        pipeVld, pipeClean, busy, resVld, exhausted;
    logic [63:0] pipeM04, resM04;
    logic [31:0] hashCnt;

    logic        pipeVld2, pipeClean2, busy2, resVld2, exhausted2;
    logic [63:0] pipeM042, resM042;
    logic [31:0] hashCnt2;

    int errors = 0;
    int checks = 0;

`ifdef SIAMINER_HASHRATE_CNT_EN
    localparam logic [63:0] HASH_AFTER_FIRST = 64'd4;
`else
    localparam logic [63:0] HASH_AFTER_FIRST = 64'd0;
`endif

    siaminer_sched #(.PIPE_DEPTH(8), .NONCE_STEP(64'd1), .NONCE_OFS(64'd0)) dut (
        .clk(clk), .rst_n(rst_n), .workVld(workVld), .workM04(workM04), .workCnt(workCnt),
        .found(found), .foundM04(foundM04), .pipeVld(pipeVld), .pipeM04(pipeM04),
        .pipeClean(pipeClean), .busy(busy), .resVld(resVld), .resM04(resM04),
        .exhausted(exhausted), .hashCnt(hashCnt)
    );

    siaminer_sched #(.PIPE_DEPTH(8), .NONCE_STEP(64'd4), .NONCE_OFS(64'd2)) dut2 (
        .clk(clk), .rst_n(rst_n), .workVld(workVld), .workM04(workM04), .workCnt(workCnt),
        .found(found), .foundM04(foundM04), .pipeVld(pipeVld2), .pipeM04(pipeM042),
        .pipeClean(pipeClean2), .busy(busy2), .resVld(resVld2), .resM04(resM042),
        .exhausted(exhausted2), .hashCnt(hashCnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        vld;
        logic        chkM04;
        logic [63:0] m04;
        logic        clean;
        logic        exh;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [63:0] wm, input logic [31:0] wc,
                                 input logic f, input logic [63:0] fm);
        workVld  = wv;
        workM04  = wm;
        workCnt  = wc;
        found    = f;
        foundM04 = fm;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Leaves the bench at the sample point of cycle T+1 (first cycle after workVld is taken).
    task automatic startWork(input logic [63:0] wm, input logic [31:0] wc);
        applyStimulus(1'b1, wm, wc, 1'b0, 64'd0);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    endtask

    function automatic void addVec(input int c, input logic v, input logic cm, input logic [63:0] m,
                                   input logic cl, input logic ex, input logic b);
        vec_t e;
        e.cyc = c; e.vld = v; e.chkM04 = cm; e.m04 = m; e.clean = cl; e.exh = ex; e.bsy = b;
        tbl.push_back(e);
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exhCount;
        int vldCount;
        int resCount;

        // Expected sequence for base 0x100, cnt 4, depth 8, step 1.
        addVec(1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        for (int j = 2; j <= 5; j++) addVec(j, 1'b1, 1'b1, 64'h100 + 64'(j - 2), 1'b0, 1'b0, 1'b1);
        for (int j = 6; j <= 12; j++) addVec(j, 1'b0, 1'b1, 64'h103, 1'b0, 1'b0, 1'b1);
        addVec(13, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        addVec(14, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        step(3);
        checkOutput("rst_pipeVld", {63'd0, pipeVld}, 64'd0);
        checkOutput("rst_pipeM04", pipeM04, 64'd0);
        checkOutput("rst_pipeClean", {63'd0, pipeClean}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_resVld", {63'd0, resVld}, 64'd0);
        checkOutput("rst_resM04", resM04, 64'd0);
        checkOutput("rst_exhausted", {63'd0, exhausted}, 64'd0);
        checkOutput("rst_hashCnt", {32'd0, hashCnt}, 64'd0);
        rst_n = 1'b1;
        step(2);

        $display("[TB] basic range, table driven");
        startWork(64'h100, 32'd4);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) step(1);
            checkOutput($sformatf("t%0d_pipeVld", tbl[i].cyc), {63'd0, pipeVld}, {63'd0, tbl[i].vld});
            if (tbl[i].chkM04)
                checkOutput($sformatf("t%0d_pipeM04", tbl[i].cyc), pipeM04, tbl[i].m04);
            checkOutput($sformatf("t%0d_pipeClean", tbl[i].cyc), {63'd0, pipeClean}, {63'd0, tbl[i].clean});
            checkOutput($sformatf("t%0d_exhausted", tbl[i].cyc), {63'd0, exhausted}, {63'd0, tbl[i].exh});
            checkOutput($sformatf("t%0d_busy", tbl[i].cyc), {63'd0, busy}, {63'd0, tbl[i].bsy});
        end
        checkOutput("hashCnt_after_first", {32'd0, hashCnt}, HASH_AFTER_FIRST);

        $display("[TB] 64-bit wrap with step 4, offset 2");
        startWork(64'hFFFF_FFFF_FFFF_FFFC, 32'd3);
        step(1);
        checkOutput("wrap_vld0", {63'd0, pipeVld2}, 64'd1);
        checkOutput("wrap_m04_0", pipeM042, 64'hFFFF_FFFF_FFFF_FFFE);
        step(1);
        checkOutput("wrap_m04_1", pipeM042, 64'h2);
        step(1);
        checkOutput("wrap_m04_2", pipeM042, 64'h6);
        step(1);
        checkOutput("wrap_vld_end", {63'd0, pipeVld2}, 64'd0);
        step(12);
        checkOutput("wrap_idle", {63'd0, busy2}, 64'd0);

        $display("[TB] hit at 10th issue");
        startWork(64'd0, 32'd100);
        step(10);
        checkOutput("hit_pre_m04", pipeM04, 64'd9);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'hDEAD);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
        checkOutput("hit_resVld", {63'd0, resVld}, 64'd1);
        checkOutput("hit_resM04", resM04, 64'hDEAD);
        checkOutput("hit_pipeVld", {63'd0, pipeVld}, 64'd0);
        checkOutput("hit_busy", {63'd0, busy}, 64'd0);
        checkOutput("hit_pipeClean", {63'd0, pipeClean}, 64'd0);
        exhCount = 0; vldCount = 0; resCount = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            exhCount += int'(exhausted);
            vldCount += int'(pipeVld);
            resCount += int'(resVld);
        end
        checkOutput("hit_no_exhausted", 64'(exhCount), 64'd0);
        checkOutput("hit_no_issue", 64'(vldCount), 64'd0);
        checkOutput("hit_single_resVld", 64'(resCount), 64'd0);

        applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'h1234);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
        checkOutput("idle_found_resVld", {63'd0, resVld}, 64'd0);
        checkOutput("idle_found_resM04", resM04, 64'hDEAD);

        $display("[TB] restart mid-run");
        startWork(64'h200, 32'd50);
        step(4);
        applyStimulus(1'b1, 64'h5000, 32'd3, 1'b0, 64'd0);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
        checkOutput("restart_clean", {63'd0, pipeClean}, 64'd1);
        checkOutput("restart_vld", {63'd0, pipeVld}, 64'd0);
        step(1);
        checkOutput("restart_vld1", {63'd0, pipeVld}, 64'd1);
        checkOutput("restart_m04", pipeM04, 64'h5000);
        exhCount = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            exhCount += int'(exhausted);
        end
        checkOutput("restart_exh_count", 64'(exhCount), 64'd1);

        $display("[TB] work and hit together in drain");
        startWork(64'h300, 32'd2);
        step(5);
        applyStimulus(1'b1, 64'h7000, 32'd1, 1'b1, 64'hBEEF);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
        checkOutput("both_resVld", {63'd0, resVld}, 64'd1);
        checkOutput("both_resM04", resM04, 64'hBEEF);
        checkOutput("both_clean", {63'd0, pipeClean}, 64'd1);
        checkOutput("both_busy", {63'd0, busy}, 64'd1);
        step(1);
        checkOutput("both_m04", pipeM04, 64'h7000);
        exhCount = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            exhCount += int'(exhausted);
        end
        checkOutput("both_exh_count", 64'(exhCount), 64'd1);

        $display("[TB] hit on final drain cycle");
        startWork(64'h10, 32'd1);
        step(8);
        checkOutput("last_pre_busy", {63'd0, busy}, 64'd1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'hF00D);
        step(1);
        applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
        checkOutput("last_resVld", {63'd0, resVld}, 64'd1);
        checkOutput("last_resM04", resM04, 64'hF00D);
        checkOutput("last_exhausted", {63'd0, exhausted}, 64'd0);
        exhCount = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            exhCount += int'(exhausted);
        end
        checkOutput("last_no_exh", 64'(exhCount), 64'd0);

        $display("[TB] zero-count work");
        startWork(64'h40, 32'd0);
        checkOutput("zero_clean", {63'd0, pipeClean}, 64'd1);
        exhCount = 0; vldCount = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            exhCount += int'(exhausted);
            vldCount += int'(pipeVld);
        end
        checkOutput("zero_early_exh", 64'(exhCount), 64'd0);
        checkOutput("zero_no_issue", 64'(vldCount), 64'd0);
        step(1);
        checkOutput("zero_exhausted", {63'd0, exhausted}, 64'd1);
        step(2);

        $display("[TB] reset during run");
        startWork(64'h400, 32'd50);
        step(4);
        checkOutput("rr_running", {63'd0, pipeVld}, 64'd1);
        rst_n = 1'b0;
        step(1);
        checkOutput("rr_pipeVld", {63'd0, pipeVld}, 64'd0);
        checkOutput("rr_pipeM04", pipeM04, 64'd0);
        checkOutput("rr_busy", {63'd0, busy}, 64'd0);
        checkOutput("rr_resM04", resM04, 64'd0);
        checkOutput("rr_exhausted", {63'd0, exhausted}, 64'd0);
        checkOutput("rr_hashCnt", {32'd0, hashCnt}, 64'd0);
        rst_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
